pulpino_flicker_endpoint: RTL

- Hardware endpoint for the processor side of the USB<->PulpIno toggle ("flicker") handshake channel; it performs the role that firmware otherwise performs through GPIO.
- RX path: consumes 32-bit words that the USB side posts with write-flicker toggles, acknowledges them, and buffers them in a small FIFO presented as a valid/ready stream.
- TX path: takes a valid/ready stream and posts each word to the USB side with write-flicker toggles, waiting for the read-flicker acknowledge.
- Sits in the pulpino_clk domain between the USB register channel and an on-fabric consumer/producer.

---
 rtl/pulpino_channel_pkg.sv | 9 +
 rtl/flicker_rx_fifo.sv | 36 +++
 rtl/pulpino_flicker_endpoint.sv | 92 +++++++++
 3 files changed

// File: rtl/pulpino_channel_pkg.sv
// pulpino_channel_pkg: shared types and constants for the USB<->PulpIno flicker channel
package pulpino_channel_pkg;
  localparam int CHANNEL_WORD_WIDTH = 32;
  localparam int USB_RD = 8;
  localparam int USB_WR = 9;
  localparam int EXT_RD = 10;
  localparam int EXT_WR = 11;
  typedef enum logic {TX_IDLE, TX_WAIT_ACK} tx_state_t;
endpackage

// File: rtl/flicker_rx_fifo.sv
// flicker_rx_fifo: synchronous FIFO with extra-MSB pointers for full/empty detection
module flicker_rx_fifo #(
  parameter int pWIDTH = 32,
  parameter int pDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [pWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [pWIDTH-1:0] pop_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(pDEPTH);
  logic [pWIDTH-1:0] mem [pDEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  // advance pointers; wrap is natural in the extra MSB
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  // storage is unreset; the empty gate keeps the head at zero after reset
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
endmodule

// File: rtl/pulpino_flicker_endpoint.sv
// pulpino_flicker_endpoint: processor-side flicker handshake endpoint with RX FIFO and TX FSM
module pulpino_flicker_endpoint
  import pulpino_channel_pkg::*;
#(
  parameter int pDATA_WIDTH  = CHANNEL_WORD_WIDTH,
  parameter int pFIFO_DEPTH  = 4,
  parameter int pSYNC_STAGES = 2,
  parameter int pCNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [pDATA_WIDTH-1:0] usb_to_pulpino_reg,
  input  logic                   usb_write_flicker,
  output logic                   pulpino_read_flicker,
  output logic [pDATA_WIDTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  input  logic [pDATA_WIDTH-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [pDATA_WIDTH-1:0] pulpino_to_usb_reg,
  output logic                   pulpino_write_flicker,
  input  logic                   usb_read_flicker,
  output logic [pCNT_WIDTH-1:0]  rx_count,
  output logic [pCNT_WIDTH-1:0]  tx_count,
  output logic                   rx_full
);
  logic wr_s, rd_s, rx_empty, rx_push;
  tx_state_t tx_state;
  generate
    if (pSYNC_STAGES == 0) begin : g_bypass
      assign wr_s = usb_write_flicker;
      assign rd_s = usb_read_flicker;
    end else begin : g_sync
      logic [pSYNC_STAGES-1:0] wr_q, rd_q;
      // shift both incoming flickers through their synchronizer chains
      always_ff @(posedge clk)
        if (!rst_n) begin
          wr_q <= '0;
          rd_q <= '0;
        end else begin
          wr_q[0] <= usb_write_flicker;
          rd_q[0] <= usb_read_flicker;
          for (int i = 1; i < pSYNC_STAGES; i++) begin
            wr_q[i] <= wr_q[i-1];
            rd_q[i] <= rd_q[i-1];
          end
        end
      assign wr_s = wr_q[pSYNC_STAGES-1];
      assign rd_s = rd_q[pSYNC_STAGES-1];
    end
  endgenerate
  assign rx_push = (wr_s != pulpino_read_flicker) && !rx_full;
  assign rx_valid = !rx_empty;
  assign tx_ready = tx_state == TX_IDLE;
  flicker_rx_fifo #(.pWIDTH(pDATA_WIDTH), .pDEPTH(pFIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (usb_to_pulpino_reg),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );
  // acknowledge each accepted word by toggling the read flicker
  always_ff @(posedge clk)
    if (!rst_n) begin
      pulpino_read_flicker <= 1'b0;
      rx_count <= '0;
    end else if (rx_push) begin
      pulpino_read_flicker <= ~pulpino_read_flicker;
      rx_count <= rx_count + 1'b1;
    end
  // post a word, then hold it until the USB side echoes the write flicker
  always_ff @(posedge clk)
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      pulpino_write_flicker <= 1'b0;
      pulpino_to_usb_reg <= '0;
      tx_count <= '0;
    end else if (tx_state == TX_IDLE) begin
      if (tx_valid) begin
        pulpino_to_usb_reg <= tx_data;
        pulpino_write_flicker <= ~pulpino_write_flicker;
        tx_state <= TX_WAIT_ACK;
      end
    end else if (rd_s == pulpino_write_flicker) begin
      tx_count <= tx_count + 1'b1;
      tx_state <= TX_IDLE;
    end
endmodule
